// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared definitions for the pipelined logic unit: opcode width and the
// eight bitwise opcode encodings used by logic_unit_core and logic_unit_pipe.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core
// Purely combinational bitwise evaluator.
// Ports:
//   a  [WIDTH-1:0] in   operand A
//   b  [WIDTH-1:0] in   operand B (unused by NOT a / PASS a)
//   op [2:0]       in   operation select
//   y  [WIDTH-1:0] out  result
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_NAND:  y = ~(a & b);
            OP_XNOR:  y = ~(a ^ b);
            OP_NOTA:  y = ~a;
            OP_PASSA: y = a;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Single-stage registered bitwise unit with valid/ready handshake, an
// accumulator that can stand in for operand B, and registered zero/parity
// flags. Optional macro LOGIC_UNIT_REDUCE_EN adds registered all_ones and
// any_one outputs.
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, op, a, b, acc_en, acc_clr   - input transaction
//   out_valid/out_ready, result, zero, parity      - registered output
//   all_ones, any_one                              - only with LOGIC_UNIT_REDUCE_EN
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef LOGIC_UNIT_REDUCE_EN
    output logic             all_ones,
    output logic             any_one,
`endif
    output logic             parity
);

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;

    // A full register may still accept when it is being drained this cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // The accumulator register already holds the previous accepted result,
    // so back-to-back accumulate transactions need no extra bypass path.
    assign w_b = acc_en ? r_acc : b;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a  (a),
        .b  (w_b),
        .op (op),
        .y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_y;
            r_zero   <= (w_y == '0);
            r_parity <= ^w_y;
        end else if (r_valid && out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // Clear has priority over the write-back; the transaction itself has
    // already used the old value through w_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= ACC_RESET;
        end else if (acc_clr) begin
            r_acc <= ACC_RESET;
        end else if (w_accept && acc_en) begin
            r_acc <= w_y;
        end
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    logic r_all_ones;
    logic r_any_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_ones <= 1'b0;
            r_any_one  <= 1'b0;
        end else if (w_accept) begin
            r_all_ones <= &w_y;
            r_any_one  <= |w_y;
        end
    end

    assign all_ones = r_all_ones;
    assign any_one  = r_any_one;
`endif

    assign out_valid = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign parity    = r_parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe: a 16-bit main instance plus 8- and
// 32-bit instances sharing the control inputs for the width sweep.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        zero;
    logic        parity;

    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready8, out_valid8, zero8, parity8;
    logic        in_ready32, out_valid32, zero32, parity32;
    logic [7:0]  result8;
    logic [31:0] result32;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic        all_ones, any_one, all_ones8, any_one8, all_ones32, any_one32;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero),
`ifdef LOGIC_UNIT_REDUCE_EN
        .all_ones(all_ones), .any_one(any_one),
`endif
        .parity(parity)
    );

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .a(a8), .b(b8), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
        .zero(zero8),
`ifdef LOGIC_UNIT_REDUCE_EN
        .all_ones(all_ones8), .any_one(any_one8),
`endif
        .parity(parity8)
    );

    logic_unit_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .op(op), .a(a32), .b(b32), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid32), .out_ready(out_ready), .result(result32),
        .zero(zero32),
`ifdef LOGIC_UNIT_REDUCE_EN
        .all_ones(all_ones32), .any_one(any_one32),
`endif
        .parity(parity32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one transaction, wait through the accepting edge, sample #1
    // later and withdraw the offer.
    task automatic issue(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                         input logic ae, input logic ac);
        op = o; a = av; b = bv; acc_en = ae; acc_clr = ac; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        $display("tx op=%0d a=%h b=%h acc_en=%0b acc_clr=%0b -> result=%h zero=%0b parity=%0b",
                 o, av, bv, ae, ac, result, zero, parity);
    endtask

    typedef struct { logic [2:0] o; logic [15:0] y; logic p; } vec_t;
    vec_t vecs [8];

    initial begin
        vecs[0] = '{OP_AND,   16'h0080, 1'b1};
        vecs[1] = '{OP_OR,    16'hB4F3, 1'b0};
        vecs[2] = '{OP_NOR,   16'h4B0C, 1'b0};
        vecs[3] = '{OP_XOR,   16'hB473, 1'b1};
        vecs[4] = '{OP_NAND,  16'hFF7F, 1'b1};
        vecs[5] = '{OP_XNOR,  16'h4B8C, 1'b1};
        vecs[6] = '{OP_NOTA,  16'h5B0E, 1'b0};
        vecs[7] = '{OP_PASSA, 16'hA4F1, 1'b0};

        // Reset state
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_zero", zero, 1'b1);
        check("rst_parity", parity, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Reset mid-transfer: hold a result, then drop rst_n asynchronously
        out_ready = 1'b0;
        issue(OP_PASSA, 16'h1234, 16'h0000, 1'b0, 1'b0);
        check("mid_valid_before", out_valid, 1'b1);
        #2; rst_n = 1'b0; #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_result", result, 16'h0000);
        check("async_rst_zero", zero, 1'b1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        issue(OP_NOR, 16'h1082, 16'h1082, 1'b0, 1'b0);
        check("post_rst_nor", result, 16'hEF7D);
        check("post_rst_nor_valid", out_valid, 1'b1);
        check("post_rst_nor_zero", zero, 1'b0);
        check("post_rst_nor_parity", parity, 1'b1);

        // All ops, back to back
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].o, 16'hA4F1, 16'h1082, 1'b0, 1'b0);
            check($sformatf("op%0d_result", i), result, vecs[i].y);
            check($sformatf("op%0d_parity", i), parity, vecs[i].p);
        end
        @(posedge clk); #1;
        check("drain_valid", out_valid, 1'b0);
        check("drain_hold", result, 16'hA4F1);

        // Backpressure
        out_ready = 1'b0;
        issue(OP_AND, 16'hA4F1, 16'h1082, 1'b0, 1'b0);
        check("bp_first", result, 16'h0080);
        op = OP_OR; a = 16'hA4F1; b = 16'h1082; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            check("bp_hold_result", result, 16'h0080);
            check("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("tx bp release -> result=%h out_valid=%0b", result, out_valid);
        check("bp_second", result, 16'hB4F3);
        check("bp_second_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        check("bp_drained", out_valid, 1'b0);
        check("bp_no_dup", result, 16'hB4F3);

        // Accumulate chain
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        issue(OP_OR, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        check("acc1", result, 16'h0001);
        issue(OP_OR, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
        check("acc2", result, 16'h0003);
        issue(OP_OR, 16'h0004, 16'hFFFF, 1'b1, 1'b0);
        check("acc3", result, 16'h0007);
        issue(OP_XOR, 16'h0007, 16'hFFFF, 1'b1, 1'b0);
        check("acc_xor", result, 16'h0000);
        check("acc_xor_zero", zero, 1'b1);

        // Clear collision
        issue(OP_OR, 16'h00FF, 16'h0000, 1'b1, 1'b1);
        issue(OP_OR, 16'h00FF, 16'h0000, 1'b1, 1'b0);
        check("acc_load_ff", result, 16'h00FF);
        issue(OP_OR, 16'h0F00, 16'h0000, 1'b1, 1'b1);
        check("clr_collision", result, 16'h0FFF);
        issue(OP_OR, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        check("clr_wins", result, 16'h0000);
        issue(OP_OR, 16'h0000, 16'h5555, 1'b0, 1'b0);
        check("no_acc_en", result, 16'h5555);
        issue(OP_OR, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        check("acc_untouched", result, 16'h0000);

        // Width sweep: NOR of zeros on all three widths
        issue(OP_NOR, 16'h0000, 16'h0000, 1'b0, 1'b0);
        $display("tx width sweep -> r8=%h r32=%h", result8, result32);
        check("w16_ones", result, 16'hFFFF);
        check("w16_parity", parity, 1'b0);
        check("w8_ones", result8, 8'hFF);
        check("w8_parity", parity8, 1'b0);
        check("w32_ones", result32, 32'hFFFF_FFFF);
        check("w32_parity", parity32, 1'b0);
`ifdef LOGIC_UNIT_REDUCE_EN
        check("w16_all_ones", all_ones, 1'b1);
        check("w16_any_one", any_one, 1'b1);
        check("w8_all_ones", all_ones8, 1'b1);
        check("w32_any_one", any_one32, 1'b1);
        issue(OP_AND, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("red_all_ones_zero", all_ones, 1'b0);
        check("red_any_one_zero", any_one32, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
